// File: rtl/id_decode_stage.sv
// ============================================================================
// Module      : id_decode_stage
// Description : ARM-subset decode stage with register file and ID/EXE register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decode_stage #(
  parameter int NREGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instruction_in,
  input  logic [3:0]  SR,
  input  logic        WB_WB_EN,
  input  logic [3:0]  WB_Dest,
  input  logic [31:0] WB_Value,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        Two_src,
  output logic [31:0] PC,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic [11:0] Shift_operand,
  output logic [23:0] Signed_imm_24,
  output logic [3:0]  Dest,
  output logic [3:0]  EXE_CMD,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN,
  output logic        B,
  output logic        S,
  output logic        Imm
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam int         IDEX_W = 146;

  logic [31:0]       rf_q [NREGS];
  logic [IDEX_W-1:0] id_exe_q;
  logic [IDEX_W-1:0] id_exe_d;

  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        s_bit;
  logic        is_store;
  logic        wb_write;
  logic        cond_ok;
  logic        n_f, z_f, c_f, v_f;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [3:0]  exe_cmd;
  logic        mem_r, mem_w, wb_en, br, s_out;

  assign mode     = Instruction_in[27:26];
  assign opcode   = Instruction_in[24:21];
  assign s_bit    = Instruction_in[20];
  assign is_store = (mode == 2'b01) && !s_bit;
  assign wb_write = WB_WB_EN && (int'(WB_Dest) < NREGS);

  assign src1    = Instruction_in[19:16];
  assign src2    = is_store ? Instruction_in[15:12] : Instruction_in[3:0];
  assign Two_src = !Instruction_in[25] || is_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_write) begin
      rf_q[WB_Dest] <= WB_Value;
    end
  end

  // Same-cycle write-back is forwarded so the reader never sees stale data.
  always_comb begin
    val_rn = '0;
    val_rm = '0;
    if (int'(src1) < NREGS) val_rn = rf_q[src1];
    if (int'(src2) < NREGS) val_rm = rf_q[src2];
    if (wb_write && (WB_Dest == src1)) val_rn = WB_Value;
    if (wb_write && (WB_Dest == src2)) val_rm = WB_Value;
  end

  assign {n_f, z_f, c_f, v_f} = SR;

  always_comb begin
    cond_ok = 1'b0;
    case (Instruction_in[31:28])
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    exe_cmd = 4'b0000;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    wb_en   = 1'b0;
    br      = 1'b0;
    s_out   = 1'b0;
    case (mode)
      2'b00: begin
        s_out = s_bit;
        wb_en = 1'b1;
        case (opcode)
          OP_MOV:  exe_cmd = 4'b0001;
          OP_MVN:  exe_cmd = 4'b1001;
          OP_ADD:  exe_cmd = 4'b0010;
          OP_ADC:  exe_cmd = 4'b0011;
          OP_SUB:  exe_cmd = 4'b0100;
          OP_SBC:  exe_cmd = 4'b0101;
          OP_AND:  exe_cmd = 4'b0110;
          OP_ORR:  exe_cmd = 4'b0111;
          OP_EOR:  exe_cmd = 4'b1000;
          OP_CMP: begin
            exe_cmd = 4'b0100;
            wb_en   = 1'b0;
          end
          OP_TST: begin
            exe_cmd = 4'b0110;
            wb_en   = 1'b0;
          end
          default: begin
            wb_en = 1'b0;
            s_out = 1'b0;
          end
        endcase
      end
      2'b01: begin
        exe_cmd = 4'b0010;
        s_out   = s_bit;
        if (s_bit) begin
          mem_r = 1'b1;
          wb_en = 1'b1;
        end else begin
          mem_w = 1'b1;
        end
      end
      2'b10: br = 1'b1;
      default: ;
    endcase
    // A failed condition or a hazard bubble kills control but keeps data.
    if (!cond_ok || hazard) begin
      exe_cmd = 4'b0000;
      mem_r   = 1'b0;
      mem_w   = 1'b0;
      wb_en   = 1'b0;
      br      = 1'b0;
      s_out   = 1'b0;
    end
  end

  assign id_exe_d = {PC_in, val_rn, val_rm, Instruction_in[11:0], Instruction_in[23:0],
                     Instruction_in[15:12], exe_cmd, mem_r, mem_w, wb_en, br, s_out,
                     Instruction_in[25]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_exe_q <= '0;
    end else if (flush) begin
      id_exe_q <= '0;
    end else if (!freeze) begin
      id_exe_q <= id_exe_d;
    end
  end

  assign {PC, Val_Rn, Val_Rm, Shift_operand, Signed_imm_24, Dest, EXE_CMD,
          MEM_R_EN, MEM_W_EN, WB_EN, B, S, Imm} = id_exe_q;

endmodule

`default_nettype wire

// File: tb/tb_id_decode_stage.sv
// ============================================================================
// Module      : tb_id_decode_stage
// Description : Scoreboard bench for id_decode_stage against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush, hazard;
  logic [31:0] PC_in, Instruction_in;
  logic [3:0]  SR;
  logic        WB_WB_EN;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic [3:0]  src1, src2;
  logic        Two_src;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest, EXE_CMD;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, B, S, Imm;

  int checks = 0;
  int errors = 0;

  logic [31:0]  rf_m [15];
  logic [145:0] last_exp;
  logic [145:0] sb [$];
  logic [145:0] e;

  id_decode_stage #(.NREGS(15)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .PC_in(PC_in), .Instruction_in(Instruction_in), .SR(SR),
    .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .src1(src1), .src2(src2), .Two_src(Two_src),
    .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Shift_operand(Shift_operand),
    .Signed_imm_24(Signed_imm_24), .Dest(Dest), .EXE_CMD(EXE_CMD),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .B(B), .S(S), .Imm(Imm)
  );

  always #5 clk = ~clk;

  function automatic logic [145:0] got();
    return {PC, Val_Rn, Val_Rm, Shift_operand, Signed_imm_24, Dest, EXE_CMD,
            MEM_R_EN, MEM_W_EN, WB_EN, B, S, Imm};
  endfunction

  function automatic logic [31:0] rd_m(input logic [3:0] a, input logic we,
                                       input logic [3:0] wd, input logic [31:0] wv);
    if (we && wd != 4'd15 && wd == a) return wv;
    if (a == 4'd15) return 32'd0;
    return rf_m[a];
  endfunction

  function automatic logic [145:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [3:0] sr, input logic hz,
                                         input logic we, input logic [3:0] wd,
                                         input logic [31:0] wv);
    logic n, z, c, v, ok, st;
    logic [3:0] cmd;
    logic mr, mw, wb, b, s;
    logic [31:0] vn, vm;
    {n, z, c, v} = sr;
    st = (ins[27:26] == 2'b01) && !ins[20];
    vn = rd_m(ins[19:16], we, wd, wv);
    vm = rd_m(st ? ins[15:12] : ins[3:0], we, wd, wv);
    cmd = 4'd0; mr = 0; mw = 0; wb = 0; b = 0; s = 0;
    if (ins[27:26] == 2'b00) begin
      case (ins[24:21])
        4'b1101: cmd = 4'b0001;
        4'b1111: cmd = 4'b1001;
        4'b0100: cmd = 4'b0010;
        4'b0101: cmd = 4'b0011;
        4'b0010: cmd = 4'b0100;
        4'b0110: cmd = 4'b0101;
        4'b0000: cmd = 4'b0110;
        4'b1100: cmd = 4'b0111;
        4'b0001: cmd = 4'b1000;
        4'b1010: cmd = 4'b0100;
        4'b1000: cmd = 4'b0110;
        default: cmd = 4'b0000;
      endcase
      if (cmd != 4'b0000) begin
        s  = ins[20];
        wb = (ins[24:21] != 4'b1010) && (ins[24:21] != 4'b1000);
      end
    end else if (ins[27:26] == 2'b01) begin
      cmd = 4'b0010; s = ins[20]; mr = ins[20]; wb = ins[20]; mw = !ins[20];
    end else if (ins[27:26] == 2'b10) begin
      b = 1'b1;
    end
    case (ins[31:28])
      4'h0: ok = z;            4'h1: ok = !z;
      4'h2: ok = c;            4'h3: ok = !c;
      4'h4: ok = n;            4'h5: ok = !n;
      4'h6: ok = v;            4'h7: ok = !v;
      4'h8: ok = c & !z;       4'h9: ok = !c | z;
      4'hA: ok = !(n ^ v);     4'hB: ok = n ^ v;
      4'hC: ok = !z & !(n ^ v); 4'hD: ok = z | (n ^ v);
      4'hE: ok = 1'b1;         default: ok = 1'b0;
    endcase
    if (!ok || hz) begin
      cmd = 4'd0; mr = 0; mw = 0; wb = 0; b = 0; s = 0;
    end
    return {pc, vn, vm, ins[11:0], ins[23:0], ins[15:12], cmd, mr, mw, wb, b, s, ins[25]};
  endfunction

  // Drives one cycle of stimulus, queues the expected ID/EXE contents, then
  // returns just after the capturing edge.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] sr,
                       input logic hz, input logic we, input logic [3:0] wd,
                       input logic [31:0] wv, input logic frz, input logic fl);
    @(negedge clk);
    Instruction_in = ins; PC_in = pc; SR = sr; hazard = hz;
    WB_WB_EN = we; WB_Dest = wd; WB_Value = wv; freeze = frz; flush = fl;
    if (fl)       e = '0;
    else if (frz) e = last_exp;
    else          e = model(ins, pc, sr, hz, we, wd, wv);
    last_exp = e;
    sb.push_back(e);
    if (we && wd != 4'd15) rf_m[wd] = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) rf_m[i] = '0;
    last_exp = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [145:0] x;
    rst = 1'b0; freeze = 0; flush = 0; hazard = 0; PC_in = 32'h4; Instruction_in = 32'hE2821007;
    SR = 0; WB_WB_EN = 0; WB_Dest = 0; WB_Value = 0;
    model_reset();
    #3;
    checks++;
    if (got() !== '0) begin errors++; $display("FAIL reset_init got=%h exp=0", got()); end
    @(negedge clk); rst = 1'b1;
    drive(32'hF0000000, 32'h8, 4'h0, 0, 1, 4'd3, 32'd5, 0, 0);
    x = sb.pop_front(); checks++;
    if (got() !== x) begin errors++; $display("FAIL reset_wr got=%h exp=%h", got(), x); end
    drive(32'hE2831000, 32'hC, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (Val_Rn !== 32'd5 || got() !== x) begin
      errors++; $display("FAIL reset_pre_r3 got=%h exp=%h", got(), x);
    end
    #2; rst = 1'b0; freeze = 1'b1; flush = 1'b1; #1;
    checks++;
    if (got() !== '0) begin errors++; $display("FAIL reset_async got=%h exp=0", got()); end
    model_reset();
    @(negedge clk); rst = 1'b1; freeze = 0; flush = 0;
    drive(32'hE2831000, 32'h10, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (Val_Rn !== 32'd0 || got() !== x) begin
      errors++; $display("FAIL reset_r3_cleared got=%h exp=%h", got(), x);
    end
  endtask

  task automatic test_add();
    logic [145:0] x;
    drive(32'hF0000000, 32'h20, 4'h0, 0, 1, 4'd2, 32'd10, 0, 0);
    x = sb.pop_front(); checks++;
    if (got() !== x) begin errors++; $display("FAIL add_wr got=%h exp=%h", got(), x); end
    drive(32'hE2821007, 32'h24, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (EXE_CMD !== 4'b0010 || WB_EN !== 1'b1 || Imm !== 1'b1 || Dest !== 4'd1 ||
        Val_Rn !== 32'd10 || Shift_operand !== 12'h007 || PC !== 32'h24) begin
      errors++; $display("FAIL add_fields cmd=%b wb=%b imm=%b dest=%0d rn=%0d sh=%h",
                         EXE_CMD, WB_EN, Imm, Dest, Val_Rn, Shift_operand);
    end
    checks++;
    if (got() !== x || Two_src !== 1'b0 || src1 !== 4'd2) begin
      errors++; $display("FAIL add_model got=%h exp=%h two=%b", got(), x, Two_src);
    end
  endtask

  task automatic test_bypass();
    logic [145:0] x;
    drive(32'hE1A01002, 32'h30, 4'h0, 0, 1, 4'd2, 32'h55, 0, 0);
    x = sb.pop_front(); checks++;
    if (Val_Rm !== 32'h55 || EXE_CMD !== 4'b0001 || Two_src !== 1'b1 || got() !== x) begin
      errors++; $display("FAIL bypass got_rm=%h exp_rm=55 got=%h exp=%h", Val_Rm, got(), x);
    end
    drive(32'hE1A01002, 32'h34, 4'h0, 0, 1, 4'd15, 32'h99, 0, 0);
    x = sb.pop_front(); checks++;
    if (Val_Rm !== 32'h55 || got() !== x) begin
      errors++; $display("FAIL r15_ignored got_rm=%h exp_rm=55", Val_Rm);
    end
  endtask

  task automatic test_cond();
    logic [145:0] x;
    drive(32'h00821007, 32'h40, 4'b0000, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (WB_EN !== 1'b0 || EXE_CMD !== 4'd0 || Val_Rn !== 32'h55 || got() !== x) begin
      errors++; $display("FAIL addeq_z0 wb=%b cmd=%b exp wb=0 cmd=0000", WB_EN, EXE_CMD);
    end
    drive(32'h00821007, 32'h44, 4'b0100, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (WB_EN !== 1'b1 || EXE_CMD !== 4'b0010 || got() !== x) begin
      errors++; $display("FAIL addeq_z1 wb=%b cmd=%b exp wb=1 cmd=0010", WB_EN, EXE_CMD);
    end
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f += 5) begin
        drive({cc[3:0], 28'h0821007}, 32'h100 + cc, f[3:0], 0, 0, 4'd0, 32'd0, 0, 0);
        x = sb.pop_front(); checks++;
        if (got() !== x) begin
          errors++; $display("FAIL cond_%0d_sr%0d got=%h exp=%h", cc, f, got(), x);
        end
      end
    end
  endtask

  task automatic test_load_store();
    logic [145:0] x;
    drive(32'hE5854008, 32'h50, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (MEM_W_EN !== 1'b1 || MEM_R_EN !== 1'b0 || WB_EN !== 1'b0 || src2 !== 4'd4 ||
        Two_src !== 1'b1 || got() !== x) begin
      errors++; $display("FAIL str mw=%b src2=%0d two=%b exp mw=1 src2=4 two=1",
                         MEM_W_EN, src2, Two_src);
    end
    drive(32'hE5954008, 32'h54, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (MEM_R_EN !== 1'b1 || WB_EN !== 1'b1 || EXE_CMD !== 4'b0010 || got() !== x) begin
      errors++; $display("FAIL ldr mr=%b wb=%b exp mr=1 wb=1", MEM_R_EN, WB_EN);
    end
    drive(32'hE2821007, 32'h58, 4'h0, 1, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (WB_EN !== 1'b0 || EXE_CMD !== 4'd0 || Dest !== 4'd1 || got() !== x) begin
      errors++; $display("FAIL hazard wb=%b cmd=%b dest=%0d", WB_EN, EXE_CMD, Dest);
    end
  endtask

  task automatic test_freeze_flush();
    logic [145:0] x;
    logic [145:0] held;
    drive(32'hE2821007, 32'h60, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); held = got(); checks++;
    if (got() !== x) begin errors++; $display("FAIL frz_load got=%h exp=%h", got(), x); end
    for (int k = 0; k < 3; k++) begin
      drive(32'hE5954008, 32'h70 + k, 4'hF, 0, k == 1, 4'd6, 32'h66, 1, 0);
      x = sb.pop_front(); checks++;
      if (got() !== x) begin
        errors++; $display("FAIL frz_hold_%0d got=%h exp=%h", k, got(), x);
      end
    end
    drive(32'hE5954008, 32'h80, 4'h0, 0, 0, 4'd0, 32'd0, 1, 1);
    x = sb.pop_front(); checks++;
    if (got() !== '0 || x !== '0) begin
      errors++; $display("FAIL flush got=%h exp=0", got());
    end
    drive(32'hE2861000, 32'h84, 4'h0, 0, 0, 4'd0, 32'd0, 0, 0);
    x = sb.pop_front(); checks++;
    if (Val_Rn !== 32'h66 || got() !== x) begin
      errors++; $display("FAIL frz_rf_write got_rn=%h exp_rn=66", Val_Rn);
    end
  endtask

  task automatic test_back_to_back();
    logic [145:0] x;
    logic [31:0]  ins;
    for (int k = 0; k < 120; k++) begin
      ins = $urandom;
      if (k % 3 == 0) ins[31:28] = 4'hE;
      drive(ins, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      x = sb.pop_front(); checks++;
      if (got() !== x) begin
        errors++; $display("FAIL b2b_%0d ins=%h got=%h exp=%h", k, ins, got(), x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_cond();
    test_load_store();
    test_freeze_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
